// File: rtl/axi_reg_seq.sv
// rtl/axi_reg_seq.sv - AXI write-then-CRC-readback sequencer for the 8-word register bank
// One command: one AW, len+1 counter-data W beats, B, then (on OKAY) a single CRC read.
module axi_reg_seq #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [3:0]            AXI_ID     = 4'h1,
   parameter logic [ADDR_WIDTH-1:0] CRC_ADDR   = 'h20,
   parameter int                    TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      areset,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
   input  logic [3:0]                cmd_len_i,
   input  logic [1:0]                cmd_burst_i,
   input  logic [DATA_WIDTH-1:0]     cmd_seed_i,
   output logic                      done_o,
   output logic [1:0]                status_o,
   output logic [DATA_WIDTH-1:0]     crc_o,
   output logic                      busy_o,
   output logic [3:0]                awid_o,
   output logic [3:0]                awlen_o,
   output logic [2:0]                awsize_o,
   output logic [1:0]                awburst_o,
   output logic [ADDR_WIDTH-1:0]     awaddr_o,
   output logic                      awvalid_o,
   input  logic                      awready_i,
   output logic [3:0]                wid_o,
   output logic [DATA_WIDTH-1:0]     wdata_o,
   output logic [DATA_WIDTH/8-1:0]   wstrb_o,
   output logic                      wlast_o,
   output logic                      wvalid_o,
   input  logic                      wready_i,
   input  logic [3:0]                bid_i,
   input  logic [1:0]                bresp_i,
   input  logic                      bvalid_i,
   output logic                      bready_o,
   output logic [3:0]                arid_o,
   output logic [ADDR_WIDTH-1:0]     araddr_o,
   output logic                      arvalid_o,
   input  logic                      arready_i,
   input  logic [3:0]                rid_i,
   input  logic [DATA_WIDTH-1:0]     rdata_i,
   input  logic                      rlast_i,
   input  logic                      rvalid_i,
   output logic                      rready_o
);

   typedef enum logic [2:0] {
      IDLE, AW, W, B, AR, R, DONE
   } state_t;

   localparam logic [15:0]           TO_LAST = 16'(TIMEOUT - 1);
   localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [3:0]              len_q;
   logic [1:0]              burst_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [3:0]              beat_q;
   logic [15:0]             wait_q;
   logic [1:0]              status_q;
   logic [DATA_WIDTH-1:0]   crc_q;
   logic                    last_beat;
   logic                    waiting;
   logic                    hs;
   logic                    timed_out;
   logic                    unused_inputs;

   assign unused_inputs = ^{bid_i, rid_i, rlast_i};

   assign last_beat = (beat_q == len_q);
   assign waiting   = (state == AW) || (state == W) || (state == B) ||
                      (state == AR) || (state == R);

   // Handshake of whichever channel the current state is waiting on.
   always_comb begin
      hs = 1'b0;
      case (state)
         AW:      hs = awready_i;
         W:       hs = wready_i;
         B:       hs = bvalid_i;
         AR:      hs = arready_i;
         R:       hs = rvalid_i;
         default: hs = 1'b0;
      endcase
   end

   // The counter reaches TIMEOUT on this edge; a handshake on the same edge wins.
   assign timed_out = waiting && (wait_q == TO_LAST) && !hs;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (cmd_valid_i) state_nx = AW;
         AW:   if (hs) state_nx = W;
         W:    if (hs && last_beat) state_nx = B;
         B:    if (hs) state_nx = (bresp_i == 2'b00) ? AR : DONE;
         AR:   if (hs) state_nx = R;
         R:    if (hs) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (timed_out) state_nx = DONE;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state    <= IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         burst_q  <= '0;
         wdata_q  <= '0;
         beat_q   <= '0;
         wait_q   <= '0;
         status_q <= '0;
         crc_q    <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && cmd_valid_i) begin
            addr_q  <= cmd_addr_i;
            len_q   <= cmd_len_i;
            burst_q <= cmd_burst_i;
            wdata_q <= cmd_seed_i;
            beat_q  <= '0;
         end
         if (state == W && wready_i && !last_beat) begin
            beat_q  <= beat_q + 4'd1;
            wdata_q <= wdata_q + ONE;
         end
         if (state == B && bvalid_i) status_q <= bresp_i;
         if (state == R && rvalid_i) crc_q <= rdata_i;
         if (timed_out) status_q <= 2'b11;
         if (state_nx != state || (state == W && wready_i))
            wait_q <= '0;
         else if (waiting)
            wait_q <= wait_q + 16'd1;
         else
            wait_q <= '0;
      end
   end

   always_comb begin
      cmd_ready_o = (state == IDLE);
      busy_o      = (state != IDLE);
      done_o      = (state == DONE);
      awvalid_o   = (state == AW);
      wvalid_o    = (state == W);
      bready_o    = (state == B);
      arvalid_o   = (state == AR);
      rready_o    = (state == R);
      wlast_o     = (state == W) && last_beat;
      araddr_o    = (state == AR) ? CRC_ADDR : '0;
   end

   assign status_o  = status_q;
   assign crc_o     = crc_q;
   assign awid_o    = AXI_ID;
   assign wid_o     = AXI_ID;
   assign arid_o    = AXI_ID;
   assign awlen_o   = len_q;
   assign awsize_o  = 3'b010;
   assign awburst_o = burst_q;
   assign awaddr_o  = addr_q;
   assign wdata_o   = wdata_q;
   assign wstrb_o   = '1;

endmodule
